// File: rtl/gray_sched.sv
// Two-requester burst scheduler that advances a shared Gray-coded step counter.
// Define GRAY_SCHED_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); otherwise round-robin.
module gray_sched #(
  parameter int CBITS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [3:0]       len0,
  input  logic [3:0]       len1,
  output logic [1:0]       gnt,
  output logic             done,
  output logic             busy,
  output logic [CBITS-1:0] gray_cnt,
  output logic             wrap
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [CBITS-1:0] cnt;
  logic [CBITS-1:0] cnt_inc;
  logic [3:0]       rem;
  logic             win;
  logic             step;
`ifndef GRAY_SCHED_FIXED_PRIO_EN
  logic             last;  // index of the requester granted most recently
`endif

  assign cnt_inc = cnt + CBITS'(1);
  assign busy    = (state != IDLE);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    win = 1'b0;
    unique case (req)
      2'b10:   win = 1'b1;
`ifdef GRAY_SCHED_FIXED_PRIO_EN
      2'b11:   win = 1'b0;
`else
      2'b11:   win = ~last;
`endif
      default: win = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = state;
    step     = 1'b0;
    unique case (state)
      IDLE: if (req != 2'b00) state_nx = STEP;
      STEP: begin
        if (rem != 4'd0) step     = 1'b1;
        else             state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      gray_cnt <= '0;
      rem      <= 4'd0;
      gnt      <= 2'b00;
      done     <= 1'b0;
      wrap     <= 1'b0;
`ifndef GRAY_SCHED_FIXED_PRIO_EN
      last     <= 1'b1;
`endif
    end else begin
      state <= state_nx;
      done  <= 1'b0;
      wrap  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req != 2'b00) begin
            gnt <= win ? 2'b10 : 2'b01;
            rem <= win ? len1 : len0;
          end
        end
        STEP: begin
          if (step) begin
            cnt      <= cnt_inc;
            gray_cnt <= cnt_inc ^ (cnt_inc >> 1);
            rem      <= rem - 4'd1;
            wrap     <= &cnt;
          end else begin
            done <= 1'b1;
          end
        end
        DONE: begin
          gnt  <= 2'b00;
`ifndef GRAY_SCHED_FIXED_PRIO_EN
          last <= gnt[1];
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/gray_sched.md
GRAY_SCHED -- requirements
Module: gray_sched

Interface
REQ-001 Parameter: CBITS, default 8, counter width in bits (legal range 2..32).
REQ-002 clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset; asserting it forces reset state immediately, releasing it is sampled on clk.
REQ-004 req  input  2  level request per requester (bit i = requester i); held until that requester's done.
REQ-005 len0  input  4  step count for requester 0, sampled at its grant.
REQ-006 len1  input  4  step count for requester 1, sampled at its grant.
REQ-007 gnt  output  2  one-hot grant, registered; all-zero when no burst is active.
REQ-008 done  output  1  one-cycle pulse ending the granted burst.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 gray_cnt  output  CBITS  registered Gray code of the internal binary counter.
REQ-011 wrap  output  1  one-cycle pulse when a step returns the counter to 0.

Function
REQ-012 Internal binary counter cnt (CBITS bits) SHALL change only by +1 steps, modulo 2^CBITS.
REQ-013 gray_cnt SHALL equal cnt ^ (cnt >> 1) of the updated cnt, in the same edge that updates cnt.
REQ-014 FSM SHALL have states IDLE, STEP, DONE.
REQ-015 IDLE: when req != 0 at an edge -> select a winner, set gnt, load rem from the winner's len, go to STEP; otherwise stay in IDLE.
REQ-016 STEP: if rem != 0 -> cnt +1, rem -1, stay in STEP; if rem == 0 -> go to DONE with no step.
REQ-017 DONE: done = 1 for exactly one cycle; on the next edge clear gnt, update the arbitration pointer, go to IDLE.
REQ-018 Latency: request seen at edge k -> steps at edges k+1..k+len; done high in the cycle after edge k+len+1; IDLE after edge k+len+2.
REQ-019 len = 0 SHALL produce a grant and a done with no step (done in the cycle after edge k+1).
REQ-020 Arbitration (default): round-robin; a single requester wins; if both request, the requester not granted last wins; the pointer updates only in DONE.
REQ-021 Deassertion of req or changes to len0/len1 during STEP/DONE SHALL NOT affect the active burst.
REQ-022 A request arriving during a burst SHALL be evaluated only in IDLE; there are no back-to-back grants without one IDLE cycle.
REQ-023 wrap SHALL pulse in the cycle after any step where cnt goes from 2^CBITS-1 to 0 (gray_cnt == 0).
REQ-024 The counter value SHALL persist across bursts; only reset clears it.

Reset
REQ-025 On rst_n low: state IDLE, cnt = 0, gray_cnt = 0, rem = 0, gnt = 0, done = 0, busy = 0, wrap = 0, arbitration pointer = last-granted requester 1 (requester 0 wins the first tie).
REQ-026 Reset asserted mid-burst SHALL abort the burst with no done pulse; outputs go to reset values immediately.

Configuration
REQ-027 Macro GRAY_SCHED_FIXED_PRIO_EN: when defined, requester 0 always wins a tie and the pointer is unused; when undefined, REQ-020 round-robin applies.

Verification
REQ-028 Reset, then req=01, len0=3 -> gnt=01 after edge 1; gray_cnt 1, 3, 2 after edges 2..4; done high in the cycle after edge 5; busy low after edge 6.
REQ-029 req=11 held, len0=1, len1=2 -> grant order 0, 1, 0, 1 (round-robin); with GRAY_SCHED_FIXED_PRIO_EN -> always 0.
REQ-030 CBITS=4, repeated bursts totalling 16 steps from reset -> wrap pulses exactly once, on the 16th step, with gray_cnt = 0.
REQ-031 req=10, len1=0 -> gnt=10, no step (gray_cnt unchanged), done pulse after edge 2.
REQ-032 rst_n low during STEP with rem=5 -> gnt, busy and gray_cnt are 0 immediately; no done pulse; after rst_n goes high, a new req=01 is served normally.
REQ-033 req=01, len0=4; drop req and change len0 to 9 after edge 2 -> exactly 4 steps occur, then one done pulse.
